// File: rtl/fp_cmp_req.sv
// Initiator-side sequencer for the FP comparator act/done handshake.
// Holds operands, pulses act, waits a bounded time for done and returns flags downstream.
module fp_cmp_req #(
   parameter int W   = 32,
   parameter int LAT = 2,
   parameter int TO  = 15,
   parameter int CW  = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [W-1:0] req_a,
   input  logic [W-1:0] req_b,
   output logic [W-1:0] cmp_in1,
   output logic [W-1:0] cmp_in2,
   output logic         cmp_act,
   input  logic         cmp_done,
   input  logic         cmp_less,
   input  logic         cmp_eq,
   input  logic         cmp_great,
   input  logic         cmp_inv,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [3:0]   rsp_flags,
   output logic         rsp_timeout,
   output logic         rsp_err,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [CW-1:0] LAT_C = CW'(LAT);
   localparam logic [CW-1:0] TO_C  = CW'(TO);
   localparam logic [CW-1:0] ONE_C = CW'(1);

   state_t         state_reg;
   logic [CW-1:0]  cnt_reg;
   logic [W-1:0]   in1_reg;
   logic [W-1:0]   in2_reg;
   logic           act_reg;
   logic           rsp_valid_reg;
   logic [3:0]     flags_reg;
   logic           timeout_reg;
   logic           err_reg;

   logic [3:0]     flags_next;
   logic [1:0]     ones_next;
   logic           err_next;

   // A valid result has exactly one ordering flag; an unordered result has at most one.
   always_comb begin
      flags_next = {cmp_less, cmp_eq, cmp_great, cmp_inv};
      ones_next  = {1'b0, cmp_less} + {1'b0, cmp_eq} + {1'b0, cmp_great};
      err_next   = cmp_inv ? (ones_next > 2'd1) : (ones_next != 2'd1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         in1_reg       <= '0;
         in2_reg       <= '0;
         act_reg       <= 1'b0;
         rsp_valid_reg <= 1'b0;
         flags_reg     <= '0;
         timeout_reg   <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  in1_reg   <= req_a;
                  in2_reg   <= req_b;
                  act_reg   <= 1'b1;
                  state_reg <= ISSUE;
               end
            end
            ISSUE: begin
               act_reg   <= 1'b0;
               cnt_reg   <= '0;
               state_reg <= WAIT;
            end
            WAIT: begin
               cnt_reg <= cnt_reg + ONE_C;
               // Early done may be left over from the previous operation.
               if (cnt_reg >= LAT_C && cmp_done) begin
                  flags_reg     <= flags_next;
                  timeout_reg   <= 1'b0;
                  err_reg       <= err_next;
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= RESP;
               end else if (cnt_reg == TO_C) begin
                  flags_reg     <= '0;
                  timeout_reg   <= 1'b1;
                  err_reg       <= 1'b0;
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  if (req_valid) begin
                     in1_reg   <= req_a;
                     in2_reg   <= req_b;
                     act_reg   <= 1'b1;
                     state_reg <= ISSUE;
                  end else begin
                     state_reg <= IDLE;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign req_ready   = (state_reg == IDLE) || (state_reg == RESP && rsp_ready);
   assign busy        = (state_reg != IDLE);
   assign cmp_in1     = in1_reg;
   assign cmp_in2     = in2_reg;
   assign cmp_act     = act_reg;
   assign rsp_valid   = rsp_valid_reg;
   assign rsp_flags   = flags_reg;
   assign rsp_timeout = timeout_reg;
   assign rsp_err     = err_reg;

endmodule

// File: tb/tb_fp_cmp_req.sv
// Self-checking bench for fp_cmp_req: vector table, randomized transactions, corner sequences.
module tb_fp_cmp_req;
   localparam int W = 32, LAT = 2, TO = 15, CW = 4;

   logic clk = 1'b0;
   logic rst;
   logic req_valid, req_ready, cmp_act, cmp_done;
   logic cmp_less, cmp_eq, cmp_great, cmp_inv;
   logic rsp_valid, rsp_ready, rsp_timeout, rsp_err, busy;
   logic [W-1:0] req_a, req_b, cmp_in1, cmp_in2;
   logic [3:0] rsp_flags;

   fp_cmp_req #(.W(W), .LAT(LAT), .TO(TO), .CW(CW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .cmp_in1(cmp_in1), .cmp_in2(cmp_in2),
      .cmp_act(cmp_act), .cmp_done(cmp_done), .cmp_less(cmp_less), .cmp_eq(cmp_eq),
      .cmp_great(cmp_great), .cmp_inv(cmp_inv), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout),
      .rsp_err(rsp_err), .busy(busy));

   always #5 clk = ~clk;

   // ds: first cycle after the act cycle (act cycle = 0) where the comparator raises done
   typedef struct {
      logic [31:0] a, b;
      int          ds;
      logic [3:0]  stale, flags;
      logic [3:0]  exp_flags;
      logic        exp_to, exp_err;
      int          exp_lat;
   } vec_t;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: done is honoured from LAT cycles after the comparator starts counting,
   // and a response is forced TO cycles after that count starts.
   task automatic model(input int ds, input logic [3:0] f,
                        output logic [3:0] ef, output logic eto, output logic eerr, output int elat);
      int t_cap, n;
      t_cap = (ds < LAT + 1) ? LAT + 1 : ds;
      if (t_cap > TO + 1) begin
         ef = 4'b0; eto = 1'b1; eerr = 1'b0; elat = TO + 2;
      end else begin
         n = int'(f[3]) + int'(f[2]) + int'(f[1]);
         ef = f; eto = 1'b0; eerr = f[0] ? (n > 1) : (n != 1); elat = t_cap + 1;
      end
   endtask

   task automatic accept(input vec_t v);
      req_valid = 1'b1; req_a = v.a; req_b = v.b;
      #1 chk("req_ready_idle", req_ready, 1'b1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // Entered one time unit after the acceptance edge; plays the comparator.
   task automatic wait_rsp(input vec_t v, output int lat);
      int act_bad = 0;
      lat = -1;
      chk("cmp_in1", cmp_in1, v.a);
      chk("cmp_in2", cmp_in2, v.b);
      chk("act_first", cmp_act, 1'b1);
      for (int t = 0; t < 40; t++) begin
         cmp_done = (t >= v.ds);
         {cmp_less, cmp_eq, cmp_great, cmp_inv} = (t <= LAT) ? v.stale : v.flags;
         if (t > 0 && cmp_act !== 1'b0) act_bad++;
         @(posedge clk); #1;
         if (rsp_valid) begin lat = t + 1; break; end
      end
      cmp_done = 1'b0;
      chk("act_single_pulse", act_bad, 0);
   endtask

   task automatic check_rsp(input logic [3:0] ef, input logic eto, input logic eerr,
                            input int elat, input int lat);
      chk("latency", lat, elat);
      chk("rsp_flags", rsp_flags, ef);
      chk("rsp_timeout", rsp_timeout, eto);
      chk("rsp_err", rsp_err, eerr);
   endtask

   task automatic finish_rsp(input int hold, input logic [3:0] ef, input logic eto, input logic eerr);
      int unstable = 0;
      rsp_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         if (!rsp_valid || rsp_flags !== ef || rsp_timeout !== eto || rsp_err !== eerr) unstable++;
      end
      chk("rsp_hold_stable", unstable, 0);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("rsp_valid_drop", rsp_valid, 1'b0);
      chk("idle_after_rsp", {busy, req_ready}, 2'b01);
   endtask

   vec_t tbl[7];
   vec_t v, v2;
   int lat, seen;
   logic [3:0] ef; logic eto, eerr; int elat;

   initial begin
      tbl[0] = '{32'h3F800000, 32'h40000000, 2,  4'b0000, 4'b1000, 4'b1000, 1'b0, 1'b0, 4};
      tbl[1] = '{32'h40400000, 32'h40400000, 0,  4'b0100, 4'b0010, 4'b0010, 1'b0, 1'b0, 4};
      tbl[2] = '{32'h12345678, 32'h9ABCDEF0, 99, 4'b0000, 4'b1000, 4'b0000, 1'b1, 1'b0, 17};
      tbl[3] = '{32'h00000001, 32'h00000002, 5,  4'b0000, 4'b1010, 4'b1010, 1'b0, 1'b1, 6};
      tbl[4] = '{32'h00000000, 32'h80000000, 4,  4'b0000, 4'b0101, 4'b0101, 1'b0, 1'b0, 5};
      tbl[5] = '{32'hAAAA5555, 32'h5555AAAA, 16, 4'b0000, 4'b0010, 4'b0010, 1'b0, 1'b0, 17};
      tbl[6] = '{32'hDEADBEEF, 32'hCAFEF00D, 17, 4'b0000, 4'b0010, 4'b0000, 1'b1, 1'b0, 17};

      rst = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      cmp_done = 1'b0; {cmp_less, cmp_eq, cmp_great, cmp_inv} = 4'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {req_ready, cmp_act, rsp_valid, rsp_flags, rsp_timeout, rsp_err, busy},
          {1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0});
      chk("reset_cmp_in", {cmp_in1, cmp_in2}, 64'h0);
      rst = 1'b1;
      @(posedge clk); #1;

      foreach (tbl[i]) begin
         accept(tbl[i]);
         wait_rsp(tbl[i], lat);
         check_rsp(tbl[i].exp_flags, tbl[i].exp_to, tbl[i].exp_err, tbl[i].exp_lat, lat);
         $display("vec %0d: a=%h b=%h flags=%b to=%b err=%b lat=%0d", i, tbl[i].a, tbl[i].b,
                  rsp_flags, rsp_timeout, rsp_err, lat);
         finish_rsp(i % 3, tbl[i].exp_flags, tbl[i].exp_to, tbl[i].exp_err);
      end

      for (int n = 0; n < 30; n++) begin
         v.a = $urandom; v.b = $urandom; v.ds = int'($urandom_range(0, 20));
         v.stale = 4'($urandom); v.flags = 4'($urandom);
         model(v.ds, v.flags, ef, eto, eerr, elat);
         accept(v);
         wait_rsp(v, lat);
         check_rsp(ef, eto, eerr, elat, lat);
         $display("rand %0d: ds=%0d flags=%b to=%b err=%b lat=%0d", n, v.ds, rsp_flags,
                  rsp_timeout, rsp_err, lat);
         finish_rsp(int'($urandom_range(0, 3)), ef, eto, eerr);
      end

      // back-to-back with 5 cycles of backpressure
      v  = tbl[0];
      v2 = '{32'h11111111, 32'h22222222, 3, 4'b0000, 4'b0011, 4'b0011, 1'b0, 1'b0, 4};
      accept(v);
      wait_rsp(v, lat);
      check_rsp(v.exp_flags, v.exp_to, v.exp_err, v.exp_lat, lat);
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         #1 if (req_ready !== 1'b0 || rsp_flags !== 4'b1000 || !rsp_valid) seen++;
         @(posedge clk); #1;
      end
      chk("b2b_backpressure_hold", seen, 0);
      rsp_ready = 1'b1; req_valid = 1'b1; req_a = v2.a; req_b = v2.b;
      #1 chk("b2b_req_ready", req_ready, 1'b1);
      @(posedge clk); #1;
      rsp_ready = 1'b0; req_valid = 1'b0;
      chk("b2b_no_idle", {rsp_valid, busy}, 2'b01);
      wait_rsp(v2, lat);
      check_rsp(v2.exp_flags, v2.exp_to, v2.exp_err, v2.exp_lat, lat);
      $display("b2b: flags=%b err=%b lat=%0d", rsp_flags, rsp_err, lat);
      finish_rsp(1, v2.exp_flags, v2.exp_to, v2.exp_err);

      // reset in the middle of WAIT abandons the operation
      v = tbl[2];
      accept(v);
      repeat (4) begin @(posedge clk); #1; end
      chk("busy_in_wait", busy, 1'b1);
      rst = 1'b0;
      #1;
      chk("midreset_outputs", {req_ready, cmp_act, rsp_valid, rsp_flags, rsp_timeout, rsp_err, busy},
          {1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0});
      chk("midreset_cmp_in", {cmp_in1, cmp_in2}, 64'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (rsp_valid || busy) seen++;
      end
      chk("no_rsp_after_abort", seen, 0);
      $display("midreset: aborted op produced %0d response cycles", seen);

      v = tbl[3];
      accept(v);
      wait_rsp(v, lat);
      check_rsp(v.exp_flags, v.exp_to, v.exp_err, v.exp_lat, lat);
      finish_rsp(0, v.exp_flags, v.exp_to, v.exp_err);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fp_cmp_req.md
Name: fp_cmp_req

Overview:
- Initiator-side sequencer for the FP comparator act/done interface.
- Accepts operand pairs from an upstream valid/ready stream, holds them stable on the comparator inputs and pulses act.
- Waits a bounded time for done, captures the less/eq/great/inv flags, and presents them downstream on a valid/ready response port.
- Adds timeout and flag-consistency checking so a hung or faulty comparator cannot stall the FPU datapath.

Parameters:
- W, 32, operand width in bits (IEEE single).
- LAT, 2, minimum cycles after the act pulse before cmp_done is honoured; covers the comparator's registered output pipeline.
- TO, 15, cycles in WAIT without an honoured done before a timeout is declared; must be greater than LAT.
- CW, 4, wait-counter width; must satisfy 2^CW > TO.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset; asynchronous, active-low.
- req_valid  input  1  upstream operand pair valid.
- req_ready  output  1  block can accept an operand pair.
- req_a  input  W  first operand.
- req_b  input  W  second operand.
- cmp_in1  output  W  comparator operand 1.
- cmp_in2  output  W  comparator operand 2.
- cmp_act  output  1  comparator start pulse.
- cmp_done  input  1  comparator result valid.
- cmp_less, cmp_eq, cmp_great, cmp_inv  input  1 each  comparator result flags.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  downstream accepts the response.
- rsp_flags  output  4  captured flags {less,eq,great,inv}.
- rsp_timeout  output  1  response produced by timeout; rsp_flags = 0.
- rsp_err  output  1  inconsistent flags captured.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (async, rst low): state = IDLE; req_ready=1; cmp_act=0; cmp_in1=cmp_in2=0; rsp_valid=0; rsp_flags=0; rsp_timeout=0; rsp_err=0; busy=0; wait counter=0.
- Reset mid-operation abandons the transaction. No response is produced for it.
- FSM, states IDLE, ISSUE, WAIT, RESP; all outputs are registered or decoded from state.
  - IDLE: req_ready=1. On req_valid, register req_a/req_b into cmp_in1/cmp_in2 and go to ISSUE.
  - ISSUE: cmp_act=1 for exactly this one cycle. Clear the counter and go to WAIT.
  - WAIT: counter increments each cycle.
    - If counter >= LAT and cmp_done=1: capture the flags, set rsp_timeout=0, go to RESP.
    - Else if counter == TO: flags=0, rsp_timeout=1, rsp_err=0, go to RESP.
    - cmp_done before LAT cycles is ignored, because the comparator may hold done high from a previous op.
  - RESP: rsp_valid=1. rsp_flags, rsp_timeout and rsp_err are stable until rsp_ready.
    - On rsp_ready with req_valid=0: go to IDLE.
    - On rsp_ready with req_valid=1: back-to-back. req_ready=1 in this cycle, the new operands are latched, go straight to ISSUE.
- req_ready = (state==IDLE) or (state==RESP and rsp_ready).
- A request is never accepted in ISSUE or WAIT.
- cmp_in1/cmp_in2 change only on request acceptance. They are stable from ISSUE through the end of WAIT and RESP.
- rsp_err is set on a done capture when:
  - inv=0 and the count of set bits in {less,eq,great} is not exactly 1, or
  - inv=1 and more than one of {less,eq,great} is set.
  - The flags are still reported as captured.
- Latency from acceptance to rsp_valid is LAT+2 cycles minimum and TO+2 cycles maximum.
- Counter saturation is not required because WAIT exits at TO.

Test Plan:
- Normal compare: req_a=0x3F800000 (1.0), req_b=0x40000000 (2.0); comparator model returns less after 2 cycles -> rsp_flags=4'b1000, rsp_timeout=0, rsp_err=0, rsp_valid asserted LAT+2=4 cycles after acceptance, cmp_act high exactly 1 cycle.
- Early stale done: hold cmp_done=1 continuously with eq, flags changing to great at counter=LAT -> captured flags=4'b0010; the pre-LAT done is ignored.
- Timeout: cmp_done held 0 -> rsp_valid after TO+2=17 cycles, rsp_flags=0, rsp_timeout=1; the next request is accepted normally.
- Back-to-back with backpressure: rsp_ready low for 5 cycles, then high together with req_valid -> response held stable for 5 cycles; the new operands are issued the cycle after the handshake, with no IDLE cycle in between.
- Inconsistent flags: comparator returns less=1, great=1, inv=0 -> rsp_err=1, rsp_flags=4'b1010. Returning eq=1, inv=1 (the +0/-0 case) -> rsp_err=0.
- Reset mid-WAIT: drop rst for 1 cycle -> all outputs return to reset values immediately, no rsp_valid for the aborted op, req_ready=1.
